// File: rtl/frame_stream_pkg.sv
// Shared types and defaults for the frame stream source.
//   state_t   : sequencer states (IDLE, RUN, FLUSH)
//   pix_tag_t : per-pixel sideband carried alongside the data through the skid FIFO
//   cnt_w()   : width of a counter that must hold 0..n-1
package frame_stream_pkg;

   localparam int unsigned DEF_IMG_W = 320;
   localparam int unsigned DEF_IMG_H = 240;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   typedef struct packed {
      logic sof;
      logic eol;
   } pix_tag_t;

   localparam int unsigned TAG_W = $bits(pix_tag_t);

   // Counter width for values 0..n-1 (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid FIFO between the frame RAM read port and the output stream.
//   clk, rst_n : clock, asynchronous active-low reset (entries cleared)
//   push/wdata : write one entry (dropped only if full with no pop)
//   pop        : remove the head entry
//   rdata      : head entry, held stable until popped
//   cnt        : number of valid entries (0..2)
module stream_skid_fifo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [1:0]       cnt
);

   logic [WIDTH-1:0] mem_q [2];
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       cnt_q;
   logic             do_push;
   logic             do_pop;

   // When full, a push is only taken alongside a pop: the freed head slot becomes the tail.
   assign do_pop  = pop && (cnt_q != 2'd0);
   assign do_push = push && ((cnt_q != 2'd2) || do_pop);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign cnt   = cnt_q;

endmodule

// File: rtl/frame_stream_source.sv
// Reads one frame from the pixel frame RAM in raster order and presents it as a
// valid/ready pixel stream (dstream source side, flattened) with sof/eol sideband.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle request to stream a frame (ignored unless idle)
//   busy           : high while a frame is being streamed
//   done           : one-cycle pulse once the last beat has been accepted
//   rd_en, rd_addr : frame RAM read strobe and raster address y*IMG_W+x
//   rd_data        : RAM data, valid the cycle after rd_en
//   y_data/y_valid/y_ready : output pixel stream
//   sof, eol       : head beat is pixel (0,0) / last pixel of a line
// rd_en is a combinational issue strobe: it depends on the same-cycle pop so the
// two-entry FIFO can sustain one beat per cycle.
module frame_stream_source
   import frame_stream_pkg::*;
#(
   parameter int unsigned W      = 30,
   parameter int unsigned IMG_W  = DEF_IMG_W,
   parameter int unsigned IMG_H  = DEF_IMG_H,
   parameter int unsigned ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [W-1:0]      rd_data,
   output logic [W-1:0]      y_data,
   output logic              y_valid,
   input  logic              y_ready,
   output logic              sof,
   output logic              eol
);

   localparam int unsigned FW = W + TAG_W;
   localparam int unsigned XW = cnt_w(IMG_W);
   localparam int unsigned YW = cnt_w(IMG_H);

   state_t          state_q;
   state_t          state_d;
   logic [XW-1:0]   x_q;
   logic [YW-1:0]   y_q;
   logic            inflight_q;
   pix_tag_t        tag_fly_q;
   logic [FW-1:0]   fifo_wdata;
   logic [FW-1:0]   fifo_rdata;
   logic [1:0]      fifo_cnt;
   pix_tag_t        head_tag;
   logic            pop;
   logic [2:0]      occ;
   logic            last_issue;
   logic            flush_done;

   // Output stream comes straight from the FIFO head registers.
   assign {head_tag, y_data} = fifo_rdata;
   assign y_valid = (fifo_cnt != 2'd0);
   assign sof     = head_tag.sof;
   assign eol     = head_tag.eol;
   assign pop     = y_valid && y_ready;

   // Read data joins the tags captured when its address was issued.
   assign fifo_wdata = {tag_fly_q, rd_data};

   stream_skid_fifo #(
      .WIDTH(FW)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (inflight_q),
      .wdata(fifo_wdata),
      .pop  (pop),
      .rdata(fifo_rdata),
      .cnt  (fifo_cnt)
   );

   // Issue a read only if the FIFO plus the in-flight read leaves room after this cycle's pop.
   always_comb begin
      occ        = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
      rd_en      = (state_q == RUN) && (occ < 3'd2);
      last_issue = rd_en && (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      flush_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (last_issue) state_d = FLUSH;
         end
         FLUSH: begin
            if ((fifo_cnt == 2'd0) && !inflight_q) begin
               state_d    = IDLE;
               flush_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Raster counters, read address, in-flight tracking and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_addr    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         inflight_q <= 1'b0;
         tag_fly_q  <= '0;
      end else begin
         done       <= flush_done;
         inflight_q <= rd_en;

         if ((state_q == IDLE) && start) begin
            busy    <= 1'b1;
            rd_addr <= '0;
            x_q     <= '0;
            y_q     <= '0;
         end else if (flush_done) begin
            busy <= 1'b0;
         end

         if (rd_en) begin
            tag_fly_q.sof <= (x_q == '0) && (y_q == '0);
            tag_fly_q.eol <= (x_q == XW'(IMG_W - 1));
            // Counters park on the last pixel; the next start reloads them.
            if (!last_issue) begin
               rd_addr <= rd_addr + ADDR_W'(1);
               if (x_q == XW'(IMG_W - 1)) begin
                  x_q <= '0;
                  y_q <= y_q + YW'(1);
               end else begin
                  x_q <= x_q + XW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed bench for frame_stream_source on a 4x2 frame with RAM[i] = i + 100.
module tb_frame_stream_source;

   localparam int unsigned W      = 30;
   localparam int unsigned IMG_W  = 4;
   localparam int unsigned IMG_H  = 2;
   localparam int unsigned ADDR_W = 17;
   localparam int          NPIX   = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [W-1:0]      rd_data = '0;
   logic [W-1:0]      y_data;
   logic              y_valid;
   logic              y_ready;
   logic              sof;
   logic              eol;

   typedef struct {
      int data;
      bit sof;
      bit eol;
      int cyc;
   } beat_t;

   beat_t beats[$];
   int    addrs[$];
   int    n_chk     = 0;
   int    n_err     = 0;
   int    n_reads   = 0;
   int    done_cnt  = 0;
   int    done_cyc  = 0;
   int    cyc       = 0;

   frame_stream_source #(
      .W(W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
      .sof(sof), .eol(eol)
   );

   always #5 clk = ~clk;

   // Frame RAM: one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= W'(100 + int'(rd_addr));
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit ready_pat(input int mode, input int c);
      case (mode)
         1:       return (c % 4 == 0) || (c % 4 == 3);
         2:       return c >= 20;
         default: return 1'b1;
      endcase
   endfunction

   // Port-level monitor: occupancy model, issue rule, stall stability, beat capture.
   initial begin
      int               occ;
      bit               infl;
      bit               pop;
      bit               prev_stall;
      logic [W+2:0]     prev_word;
      beat_t            b;
      occ = 0; infl = 0; prev_stall = 0; prev_word = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            occ = 0; infl = 0; prev_stall = 0;
         end else begin
            pop = y_valid && y_ready;
            chk("valid_vs_occ", 64'(y_valid), 64'(occ != 0));
            if (prev_stall)
               chk("stall_hold", 64'({y_valid, sof, eol, y_data}), 64'(prev_word));
            if (rd_en) begin
               chk("issue_rule", 64'((occ + int'(infl) - int'(pop)) < 2), 64'(1));
               chk("rd_addr_seq", 64'(rd_addr), 64'(n_reads));
               addrs.push_back(int'(rd_addr));
               n_reads++;
            end
            if (pop) begin
               b.data = int'(y_data);
               b.sof  = sof;
               b.eol  = eol;
               b.cyc  = cyc;
               beats.push_back(b);
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            occ = occ + int'(infl) - int'(pop);
            if (infl) chk("fifo_bound", 64'(occ <= 2), 64'(1));
            infl       = rd_en;
            prev_stall = y_valid && !y_ready;
            prev_word  = {1'b1, sof, eol, y_data};
         end
      end
   end

   // Drives one frame; mode 0 full rate, 1 ready 1001, 2 ready low 20 cycles,
   // 3 extra start mid-frame, 4 reset after the third accepted beat.
   task automatic run_frame(input int mode);
      bit fin;
      fin = 0;
      beats.delete();
      addrs.delete();
      n_reads  = 0;
      done_cnt = 0;
      for (int c = 0; c < 400 && !fin; c++) begin
         start   = (c == 0) || (mode == 3 && c == 5);
         y_ready = ready_pat(mode, c);
         tick();
         start = 1'b0;
         if (mode == 0 && c == 0) begin
            chk("lat_rd_en_c1", 64'(rd_en), 64'(1));
            chk("lat_rd_addr_c1", 64'(rd_addr), 64'(0));
            chk("lat_busy_c1", 64'(busy), 64'(1));
            chk("lat_valid_c1", 64'(y_valid), 64'(0));
         end
         if (mode == 0 && c == 1) chk("lat_valid_c2", 64'(y_valid), 64'(0));
         if (mode == 0 && c == 2) begin
            chk("lat_valid_c3", 64'(y_valid), 64'(1));
            chk("lat_data_c3", 64'(y_data), 64'(100));
            chk("lat_sof_c3", 64'(sof), 64'(1));
         end
         if (mode == 2 && c == 18) begin
            chk("stall_reads", 64'(n_reads), 64'(2));
            if (addrs.size() == 2) chk("stall_addr1", 64'(addrs[1]), 64'(1));
         end
         if (mode == 4 && beats.size() == 3) begin
            rst_n = 1'b0;
            #1;
            chk("abort_flags", 64'({busy, done, rd_en, y_valid, sof, eol}), 64'(0));
            chk("abort_addr", 64'(rd_addr), 64'(0));
            chk("abort_data", 64'(y_data), 64'(0));
            fin = 1;
         end
         if (done_cnt != 0) fin = 1;
      end
      if (mode != 4) begin
         chk("frame_done_seen", 64'(done_cnt != 0), 64'(1));
         chk("busy_end", 64'(busy), 64'(0));
         chk("done_one_cycle", 64'(done), 64'(0));
      end
   endtask

   task automatic check_frame(input string tag, input bit timing);
      chk({tag, "_beats"}, 64'(beats.size()), 64'(NPIX));
      for (int i = 0; i < beats.size() && i < NPIX; i++) begin
         chk($sformatf("%s_data%0d", tag, i), 64'(beats[i].data), 64'(100 + i));
         chk($sformatf("%s_sof%0d", tag, i), 64'(beats[i].sof), 64'(i == 0));
         chk($sformatf("%s_eol%0d", tag, i), 64'(beats[i].eol), 64'(i % IMG_W == IMG_W - 1));
         if (timing)
            chk($sformatf("%s_gap%0d", tag, i), 64'(beats[i].cyc), 64'(beats[0].cyc + i));
      end
      if (beats.size() > 0)
         chk({tag, "_done_after_last"}, 64'(done_cyc > beats[beats.size()-1].cyc), 64'(1));
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      y_ready = 1'b0;
      repeat (3) tick();
      chk("rst_flags", 64'({busy, done, rd_en, y_valid, sof, eol}), 64'(0));
      chk("rst_addr", 64'(rd_addr), 64'(0));
      chk("rst_data", 64'(y_data), 64'(0));
      rst_n = 1'b1;
      repeat (2) tick();

      run_frame(0);
      check_frame("full", 1'b1);
      repeat (5) tick();
      chk("full_one_done", 64'(done_cnt), 64'(1));

      run_frame(1);
      check_frame("bp", 1'b0);

      run_frame(2);
      check_frame("stall", 1'b0);

      run_frame(3);
      repeat (10) tick();
      check_frame("dblstart", 1'b0);
      chk("dblstart_one_done", 64'(done_cnt), 64'(1));
      chk("dblstart_idle", 64'(busy), 64'(0));

      run_frame(4);
      repeat (2) tick();
      chk("abort_no_done", 64'(done_cnt), 64'(0));
      rst_n = 1'b1;
      tick();
      run_frame(0);
      check_frame("after_rst", 1'b1);

      // Second frame starts in the cycle right after the first frame's done.
      run_frame(0);
      check_frame("b2b_a", 1'b1);
      run_frame(0);
      check_frame("b2b_b", 1'b1);
      repeat (5) tick();
      chk("b2b_one_done", 64'(done_cnt), 64'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
- Producer end of the dstream pixel interface.
- Reads one frame from a pixel frame RAM in raster order and drives it as a valid/ready stream into the convolution pipeline (the x input of edge_conv).
- Supplies start-of-frame and end-of-line sideband so downstream line buffers can align.
- Decouples RAM read latency from downstream backpressure.

Parameters:
- W, 30, pixel/stream data width (matches dstream N).
- IMG_W, 320, pixels per line.
- IMG_H, 240, lines per frame.
- ADDR_W, 17, frame RAM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to stream one frame.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- rd_en  out  1  frame RAM read strobe.
- rd_addr  out  ADDR_W  frame RAM read address, raster index y*IMG_W+x.
- rd_data  in  W  RAM data, valid exactly 1 cycle after rd_en.
- y  dstream #(.N(W)) source side:
  - y.data  out  W
  - y.valid  out  1
  - y.ready  in  1
- sof  out  1  qualifies the current y beat as pixel (0,0).
- eol  out  1  qualifies the current y beat as x==IMG_W-1.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, rd_en, y.valid, sof, eol = 0; rd_addr, y.data = 0; counters and FIFO cleared.
- Reset mid-frame aborts the frame immediately. No done pulse. In-flight RAM data is discarded.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> FLUSH in the cycle after the last address (IMG_W*IMG_H-1) is issued.
  - FLUSH -> IDLE when FIFO is empty, no read is in flight and no beat is pending. done pulses in that transition cycle.
- start is ignored when not in IDLE.
- Read issue: rd_en=1 in RUN when (fifo_cnt + inflight - pop) < 2, where pop = y.valid & y.ready in the same cycle.
  - rd_addr increments by 1 per issued read.
  - inflight is a 1-bit flag set the cycle after rd_en.
- Buffering: 2-entry skid FIFO. rd_data is written on the edge ending its valid cycle, together with sof/eol tags from the x/y counters captured at issue time.
  - The FIFO never overflows: the issue rule guarantees this; the bench asserts it.
- Output: y.valid = FIFO not empty. y.data, sof and eol come from the FIFO head.
  - While y.valid & !y.ready, y.data/sof/eol are held stable.
  - y.valid does not drop until the beat is accepted.
- Latency: start high in cycle 0 -> rd_en/rd_addr=0 in cycle 1 -> rd_data in cycle 2 -> y.valid=1 in cycle 3.
- Throughput: with y.ready held high, one beat per cycle continuously and no bubbles after the first.
- Counters:
  - x wraps IMG_W-1 -> 0 and increments y.
  - y reaching IMG_H-1 with x=IMG_W-1 marks the last address.
  - All arithmetic is unsigned, no overflow by construction.
- Simultaneous push and pop on the FIFO in the same cycle: fifo_cnt is unchanged and ordering is preserved.

Decomposition:
- frame_stream_pkg holds:
  - the state enum (IDLE, RUN, FLUSH);
  - default IMG_W, IMG_H;
  - the pixel tag struct {sof, eol}.
- Sub-module stream_skid_fifo: depth 2, parameterised width W+2, push/pop/count.

Test Plan:
- Full throughput: IMG_W=4, IMG_H=2, RAM[i]=i+100, y.ready=1, start in cycle 0.
  - y.valid rises in cycle 3.
  - Data 100..107 on consecutive cycles.
  - sof only on 100; eol on 103 and 107.
  - done pulses once after 107 is accepted; busy returns to 0.
- Backpressure: same frame, y.ready toggles 1,0,0,1 repeating.
  - All 8 values arrive in order, none duplicated or lost.
  - y.data is stable during every stall.
  - rd_en never fires while the FIFO plus in-flight read already holds 2 entries.
- Ready low from start: y.ready=0 for 20 cycles, then 1.
  - Exactly 2 reads are issued (addr 0,1) before the stall.
  - Stream then resumes 100..107.
- start while busy: assert start in cycle 5 of a frame.
  - Ignored; exactly one frame of 8 beats and one done pulse.
- Reset mid-frame: drop rst_n after the 3rd beat is accepted.
  - All outputs go to 0 immediately; no done.
  - A new start then streams a full frame from address 0 with sof on the first beat.
- Back-to-back frames: start in the cycle after done.
  - Second frame identical to the first; no sof on any beat other than each frame's first.
